// File: rtl/game_pkg.sv
// Shared game-control constants: USB keycodes and the key filter state encoding.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package game_pkg;

  localparam logic [7:0] KEY_NONE  = 8'h00;
  localparam logic [7:0] KEY_MENU  = 8'h10;
  localparam logic [7:0] KEY_PAUSE = 8'h13;
  localparam logic [7:0] KEY_JUMP  = 8'h1A;
  localparam logic [7:0] KEY_START = 8'h2C;

  typedef enum logic [1:0] {
    S_STABLE = 2'd0,
    S_QUAL   = 2'd1,
    S_COMMIT = 2'd2
  } kef_state_t;

endpackage

// File: rtl/key_event_filter.sv
// Debounces the raw USB keycode and turns each qualified new press into a one-cycle event.
// Latency: key_held on the edge capturing the STABLE_CNT-th matching sample, event one cycle later.
// Backpressure: none; sample_en gates qualification, the event always fires the cycle after commit.
module key_event_filter
  import game_pkg::*;
#(
  parameter int unsigned STABLE_CNT = 3,
  parameter logic [7:0]  JUMP_CODE  = KEY_JUMP
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       sample_en,
  input  logic [7:0] keycode_raw,
  output logic [7:0] keycode_evt,
  output logic       key_valid,
  output logic [7:0] key_held,
  output logic       jump_held
);

  localparam int unsigned    CW      = $clog2(STABLE_CNT + 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [CW-1:0] CNT_TGT = CW'(STABLE_CNT);

  kef_state_t    state, state_nxt;
  logic [7:0]    cand, cand_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [7:0]    held_nxt;
  logic          commit;

  // Next-state logic: track a candidate code and count consecutive matching samples.
  always_comb begin
    state_nxt = state;
    cand_nxt  = cand;
    cnt_nxt   = cnt;
    held_nxt  = key_held;
    commit    = 1'b0;
    case (state)
      S_STABLE: begin
        if (sample_en && (keycode_raw != key_held)) begin
          cand_nxt  = keycode_raw;
          cnt_nxt   = CNT_ONE;
          state_nxt = S_QUAL;
          // A single required sample qualifies on the very sample that saw the change.
          if (CNT_TGT == CNT_ONE) commit = 1'b1;
        end
      end
      S_QUAL: begin
        if (sample_en) begin
          if (keycode_raw == key_held) begin
            // Bounced back to the committed value: drop the candidate silently.
            cnt_nxt   = '0;
            state_nxt = S_STABLE;
          end else if (keycode_raw != cand) begin
            cand_nxt = keycode_raw;
            cnt_nxt  = CNT_ONE;
          end else if ((cnt + CNT_ONE) == CNT_TGT) begin
            commit = 1'b1;
          end else begin
            cnt_nxt = cnt + CNT_ONE;
          end
        end
      end
      S_COMMIT: begin
        // Event cycle; any sample arriving now is deliberately ignored.
        state_nxt = S_STABLE;
      end
      default: begin
        state_nxt = S_STABLE;
      end
    endcase
    if (commit) begin
      held_nxt  = cand_nxt;
      cnt_nxt   = '0;
      // Releases update key_held but never produce an event.
      state_nxt = (cand_nxt != KEY_NONE) ? S_COMMIT : S_STABLE;
    end
  end

  // Qualification state registers.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state <= S_STABLE;
      cand  <= KEY_NONE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cand  <= cand_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Registered outputs; the event is emitted from the S_COMMIT cycle so it trails key_held by one.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      key_held    <= KEY_NONE;
      jump_held   <= 1'b0;
      keycode_evt <= KEY_NONE;
      key_valid   <= 1'b0;
    end else begin
      key_held    <= held_nxt;
      jump_held   <= (held_nxt == JUMP_CODE);
      keycode_evt <= (state == S_COMMIT) ? key_held : KEY_NONE;
      key_valid   <= (state == S_COMMIT);
    end
  end

endmodule

// File: tb/tb_key_event_filter.sv
// Self-checking bench for key_event_filter (STABLE_CNT 3 and 1 instances).
// Latency: expected events carry the cycle they must appear in.
// Backpressure: n/a.
module tb_key_event_filter;
  import game_pkg::*;

  typedef struct {
    int         cyc;
    logic [7:0] code;
  } exp_t;

  logic       Clk = 1'b0;
  logic       Reset_n = 1'b0;
  logic       sample_en, sample_en2;
  logic [7:0] raw, raw2;
  logic [7:0] keycode_evt, key_held, keycode_evt2, key_held2;
  logic       key_valid, jump_held, key_valid2, jump_held2;

  int   cyc = 0;
  int   n_chk = 0;
  int   n_pass = 0;
  exp_t q1[$];
  exp_t q2[$];
  logic prev_valid2 = 1'b0;

  key_event_filter #(.STABLE_CNT(3), .JUMP_CODE(KEY_JUMP)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .sample_en(sample_en), .keycode_raw(raw),
    .keycode_evt(keycode_evt), .key_valid(key_valid), .key_held(key_held), .jump_held(jump_held)
  );

  key_event_filter #(.STABLE_CNT(1), .JUMP_CODE(KEY_JUMP)) dut1 (
    .Clk(Clk), .Reset_n(Reset_n), .sample_en(sample_en2), .keycode_raw(raw2),
    .keycode_evt(keycode_evt2), .key_valid(key_valid2), .key_held(key_held2), .jump_held(jump_held2)
  );

  always #5 Clk = ~Clk;

  always @(posedge Clk) cyc <= cyc + 1;

  // Scoreboard for the STABLE_CNT=3 instance.
  always @(negedge Clk) begin : mon1
    exp_t e;
    if (q1.size() > 0 && q1[0].cyc < cyc) begin
      e = q1.pop_front();
      n_chk++;
      $display("FAIL evt1_missing: no event seen, expected code %h at cycle %0d", e.code, e.cyc);
    end
    if (Reset_n && (key_valid !== 1'b0 || keycode_evt !== 8'h00)) begin
      n_chk++;
      if (q1.size() == 0) begin
        $display("FAIL evt1_unexpected: got code %h valid %b at cycle %0d, expected no event",
                 keycode_evt, key_valid, cyc);
      end else begin
        e = q1.pop_front();
        if (key_valid === 1'b1 && keycode_evt === e.code && cyc == e.cyc) n_pass++;
        else $display("FAIL evt1_match: got code %h valid %b cycle %0d, expected code %h valid 1 cycle %0d",
                      keycode_evt, key_valid, cyc, e.code, e.cyc);
      end
    end
  end

  // Scoreboard for the STABLE_CNT=1 instance, also rejecting back-to-back valid cycles.
  always @(negedge Clk) begin : mon2
    exp_t e;
    if (q2.size() > 0 && q2[0].cyc < cyc) begin
      e = q2.pop_front();
      n_chk++;
      $display("FAIL evt2_missing: no event seen, expected code %h at cycle %0d", e.code, e.cyc);
    end
    if (Reset_n && (key_valid2 !== 1'b0 || keycode_evt2 !== 8'h00)) begin
      n_chk++;
      if (q2.size() == 0) begin
        $display("FAIL evt2_unexpected: got code %h valid %b at cycle %0d, expected no event",
                 keycode_evt2, key_valid2, cyc);
      end else begin
        e = q2.pop_front();
        if (key_valid2 === 1'b1 && keycode_evt2 === e.code && cyc == e.cyc) n_pass++;
        else $display("FAIL evt2_match: got code %h valid %b cycle %0d, expected code %h valid 1 cycle %0d",
                      keycode_evt2, key_valid2, cyc, e.code, e.cyc);
      end
      n_chk++;
      if (prev_valid2 === 1'b1) $display("FAIL evt2_back_to_back: valid high two cycles running at cycle %0d, expected isolated", cyc);
      else n_pass++;
    end
    prev_valid2 = key_valid2;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge Clk);
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) @(negedge Clk);
  endtask

  task automatic test_reset();
    Reset_n = 1'b0;
    tick(2);
    n_chk++; if (keycode_evt !== 8'h00) $display("FAIL rst_evt: got %h expected 00", keycode_evt); else n_pass++;
    n_chk++; if (key_valid !== 1'b0) $display("FAIL rst_valid: got %b expected 0", key_valid); else n_pass++;
    n_chk++; if (key_held !== 8'h00) $display("FAIL rst_held: got %h expected 00", key_held); else n_pass++;
    n_chk++; if (jump_held !== 1'b0) $display("FAIL rst_jump: got %b expected 0", jump_held); else n_pass++;
    Reset_n = 1'b1;
    tick(3);
  endtask

  task automatic test_press();
    int c, d;
    c = cyc;
    raw = KEY_PAUSE;
    q1.push_back('{c + 4, KEY_PAUSE});
    wait_until(c + 2);
    n_chk++; if (key_held !== 8'h00) $display("FAIL press_held_early: got %h expected 00", key_held); else n_pass++;
    wait_until(c + 3);
    n_chk++; if (key_held !== KEY_PAUSE) $display("FAIL press_held: got %h expected 13", key_held); else n_pass++;
    wait_until(c + 20);
    d = cyc;
    raw = KEY_NONE;
    wait_until(d + 2);
    n_chk++; if (key_held !== KEY_PAUSE) $display("FAIL release_held_early: got %h expected 13", key_held); else n_pass++;
    wait_until(d + 3);
    n_chk++; if (key_held !== 8'h00) $display("FAIL release_held: got %h expected 00", key_held); else n_pass++;
    n_chk++; if (jump_held !== 1'b0) $display("FAIL press_jump: got %b expected 0", jump_held); else n_pass++;
    tick(3);
    n_chk++; if (q1.size() != 0) $display("FAIL press_pending: got %0d queued expected 0", q1.size()); else n_pass++;
  endtask

  task automatic test_glitch();
    for (int i = 0; i < 10; i++) begin
      raw = KEY_START;
      tick(2);
      raw = KEY_NONE;
      tick(2);
      n_chk++; if (key_held !== 8'h00) $display("FAIL glitch_held_%0d: got %h expected 00", i, key_held); else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    int c;
    c = cyc;
    raw = KEY_MENU;
    q1.push_back('{c + 4, KEY_MENU});
    wait_until(c + 3);
    n_chk++; if (key_held !== KEY_MENU) $display("FAIL b2b_held_menu: got %h expected 10", key_held); else n_pass++;
    wait_until(c + 5);
    raw = KEY_START;
    q1.push_back('{c + 9, KEY_START});
    wait_until(c + 8);
    n_chk++; if (key_held !== KEY_START) $display("FAIL b2b_held_start: got %h expected 2c", key_held); else n_pass++;
    tick(2);
    raw = KEY_NONE;
    tick(5);
    n_chk++; if (key_held !== 8'h00) $display("FAIL b2b_release: got %h expected 00", key_held); else n_pass++;
    n_chk++; if (q1.size() != 0) $display("FAIL b2b_pending: got %0d queued expected 0", q1.size()); else n_pass++;
  endtask

  task automatic test_jump_strobe();
    int s;
    logic [7:0] hb, ha;
    sample_en = 1'b0;
    raw = KEY_JUMP;
    for (int i = 0; i < 5; i++) begin
      tick(1);
      s = cyc;
      hb = (i >= 3) ? KEY_JUMP : 8'h00;
      ha = (i >= 2) ? KEY_JUMP : 8'h00;
      n_chk++; if (jump_held !== (i >= 3)) $display("FAIL strobe_jump_pre_%0d: got %b expected %b", i, jump_held, (i >= 3)); else n_pass++;
      n_chk++; if (key_held !== hb) $display("FAIL strobe_held_pre_%0d: got %h expected %h", i, key_held, hb); else n_pass++;
      sample_en = 1'b1;
      if (i == 2) q1.push_back('{s + 2, KEY_JUMP});
      tick(1);
      sample_en = 1'b0;
      n_chk++; if (jump_held !== (i >= 2)) $display("FAIL strobe_jump_post_%0d: got %b expected %b", i, jump_held, (i >= 2)); else n_pass++;
      n_chk++; if (key_held !== ha) $display("FAIL strobe_held_post_%0d: got %h expected %h", i, key_held, ha); else n_pass++;
      tick(2);
    end
    sample_en = 1'b1;
    raw = KEY_NONE;
    tick(5);
    n_chk++; if (jump_held !== 1'b0) $display("FAIL strobe_jump_release: got %b expected 0", jump_held); else n_pass++;
    n_chk++; if (q1.size() != 0) $display("FAIL strobe_pending: got %0d queued expected 0", q1.size()); else n_pass++;
  endtask

  task automatic test_reset_mid();
    int c, r;
    c = cyc;
    raw = KEY_PAUSE;
    wait_until(c + 2);
    Reset_n = 1'b0;
    #1;
    n_chk++; if (key_held !== 8'h00) $display("FAIL rqual_held: got %h expected 00", key_held); else n_pass++;
    n_chk++; if (key_valid !== 1'b0) $display("FAIL rqual_valid: got %b expected 0", key_valid); else n_pass++;
    tick(2);
    n_chk++; if (key_held !== 8'h00) $display("FAIL rqual_held_hold: got %h expected 00", key_held); else n_pass++;
    Reset_n = 1'b1;
    r = cyc;
    q1.push_back('{r + 4, KEY_PAUSE});
    wait_until(r + 3);
    n_chk++; if (key_held !== KEY_PAUSE) $display("FAIL rqual_requalify: got %h expected 13", key_held); else n_pass++;
    tick(3);
    raw = KEY_NONE;
    tick(5);
    // Reset landing in the commit cycle must swallow the pending event.
    c = cyc;
    raw = KEY_MENU;
    wait_until(c + 3);
    n_chk++; if (key_held !== KEY_MENU) $display("FAIL rcommit_pre: got %h expected 10", key_held); else n_pass++;
    Reset_n = 1'b0;
    #1;
    n_chk++; if (key_held !== 8'h00) $display("FAIL rcommit_held: got %h expected 00", key_held); else n_pass++;
    n_chk++; if (keycode_evt !== 8'h00) $display("FAIL rcommit_evt: got %h expected 00", keycode_evt); else n_pass++;
    tick(2);
    raw = KEY_NONE;
    Reset_n = 1'b1;
    tick(5);
    n_chk++; if (q1.size() != 0) $display("FAIL rmid_pending: got %0d queued expected 0", q1.size()); else n_pass++;
  endtask

  task automatic test_stable_one();
    int c, a;
    c = cyc;
    raw2 = KEY_PAUSE;
    q2.push_back('{c + 2, KEY_PAUSE});
    wait_until(c + 1);
    n_chk++; if (key_held2 !== KEY_PAUSE) $display("FAIL s1_held: got %h expected 13", key_held2); else n_pass++;
    tick(3);
    raw2 = KEY_NONE;
    tick(3);
    n_chk++; if (key_held2 !== 8'h00) $display("FAIL s1_release: got %h expected 00", key_held2); else n_pass++;
    for (int i = 0; i < 8; i++) begin
      a = cyc;
      raw2 = (i % 2 == 0) ? KEY_PAUSE : KEY_NONE;
      if (i % 4 == 0) q2.push_back('{a + 2, KEY_PAUSE});
      tick(1);
    end
    raw2 = KEY_NONE;
    tick(4);
    n_chk++; if (q2.size() != 0) $display("FAIL s1_pending: got %0d queued expected 0", q2.size()); else n_pass++;
  endtask

  initial begin
    sample_en  = 1'b1;
    sample_en2 = 1'b1;
    raw  = KEY_NONE;
    raw2 = KEY_NONE;
    test_reset();
    test_press();
    test_glitch();
    test_back_to_back();
    test_jump_strobe();
    test_reset_mid();
    test_stable_one();
    tick(2);
    n_chk++; if (q1.size() + q2.size() != 0) $display("FAIL final_pending: got %0d queued expected 0", q1.size() + q2.size()); else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at time limit, expected completion");
    $fatal(1, "time limit");
  end

endmodule
